seg_display_driver: RTL and testbench

//  Consumer of the 2-bit display-priority select for the octurdle board.

---
 rtl/seg_display_driver_if.sv | 21 ++
 rtl/seg_display_driver.sv | 167 ++++++++++++++++
 tb/tb_seg_display_driver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg_display_driver_if.sv
// Display-side bundle for seg_display_driver: source select, data words and the
// multiplexed seven-segment outputs.
interface seg_display_driver_if;
    logic [1:0]  sel_bits;
    logic [15:0] score_val;
    logic [15:0] random_val;
    logic [15:0] switch_val;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output sel_bits, score_val, random_val, switch_val,
        input  an, seg, dp
    );

    modport slave (
        input  sel_bits, score_val, random_val, switch_val,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_display_driver.sv
// Four-digit common-anode seven-segment scanner with frame-aligned source switching.
// Optional random-source blink is enabled by defining SEG_BLINK_EN.
module seg_display_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    seg_display_driver_if.slave  disp
);

    localparam int unsigned     CntW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

    localparam logic [1:0] SelScore  = 2'b00;
    localparam logic [1:0] SelSwitch = 2'b01;
    localparam logic [1:0] SelIdle   = 2'b10;
    localparam logic [1:0] SelRandom = 2'b11;

    localparam logic [6:0] SegDash = 7'b0111111;
    localparam logic [6:0] SegOff  = 7'b1111111;

    if (REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_cfg
        $error("seg_display_driver: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic        tick;
    logic        frame_end;
    logic        blank;
    logic [15:0] src;
    logic [3:0]  nibble;

    assign tick      = (cnt_q == CntLast);
    assign frame_end = tick && (digit_q == 2'd3);

    // Scan timing and frame-aligned source latch.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        sel_d   = sel_q;
        if (tick) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end
        if (frame_end) begin
            sel_d = disp.sel_bits;
        end
    end

    // Data words are sampled live; only the selection is frame-latched.
    always_comb begin
        src = 16'h0000;
        unique case (sel_q)
            SelScore:  src = disp.score_val;
            SelSwitch: src = disp.switch_val;
            SelRandom: src = disp.random_val;
            default:   src = 16'h0000;
        endcase
    end

    always_comb begin
        nibble = 4'h0;
        unique case (digit_q)
            2'd0:    nibble = src[3:0];
            2'd1:    nibble = src[7:4];
            2'd2:    nibble = src[11:8];
            default: nibble = src[15:12];
        endcase
    end

    always_comb begin
        an_d  = ~(4'b0001 << digit_q);
        seg_d = (sel_q == SelIdle) ? SegDash : hex7(nibble);
        if (blank) begin
            an_d = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            digit_q <= 2'd0;
            sel_q   <= SelIdle;
            an_q    <= 4'b1111;
            seg_q   <= SegOff;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned      FcntW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FcntW-1:0] FcntLast = FcntW'(BLINK_FRAMES - 1);

    logic [FcntW-1:0] fcnt_q, fcnt_d;
    logic             phase_q, phase_d;

    // Blink state is held cleared outside the random source, so entry starts visible.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (sel_q != SelRandom) begin
            fcnt_d  = '0;
            phase_d = 1'b0;
        end else if (frame_end) begin
            if (fcnt_q == FcntLast) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blank = (sel_q == SelRandom) && phase_q;
`else
    assign blank = 1'b0;
`endif

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed-vector bench for seg_display_driver with REFRESH_DIV=4, BLINK_FRAMES=2.
// Builds with or without SEG_BLINK_EN; blink rows adapt their expected anodes.
module tb_seg_display_driver;

    localparam logic [15:0] ScoreA = 16'h1234;
    localparam logic [15:0] ScoreB = 16'h5678;
    localparam logic [15:0] SwVal  = 16'h8888;
    localparam logic [15:0] RndVal = 16'hFFFF;
    localparam logic [6:0]  Dash   = 7'b0111111;

    typedef struct {
        int unsigned cyc;    // edge index after first reset release
        logic        rst;    // inputs driven right after this edge
        logic [1:0]  sel;
        logic [15:0] score;
        logic [3:0]  an;     // expected outputs at this edge
        logic [6:0]  seg;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    seg_display_driver_if disp();

    seg_display_driver #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .disp (disp)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned edge_n   = 0;
    vec_t        vq[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    function automatic vec_t mk(input int unsigned c, input logic r, input logic [1:0] s,
                                input logic [15:0] sc, input logic [3:0] a,
                                input logic [6:0] g);
        vec_t v;
        v.cyc = c; v.rst = r; v.sel = s; v.score = sc; v.an = a; v.seg = g;
        return v;
    endfunction

    function automatic logic [3:0] bl(input logic [3:0] a);
`ifdef SEG_BLINK_EN
        return 4'b1111;
`else
        return a;
`endif
    endfunction

    initial begin
        int cnt0;
        int cnt3;

        // Idle dashes, then score 1234, switch swap mid-frame, live data change.
        vq.push_back(mk(1,   0, 2'b00, ScoreA, 4'b1110, Dash));
        vq.push_back(mk(8,   0, 2'b00, ScoreA, 4'b1101, Dash));
        vq.push_back(mk(16,  0, 2'b00, ScoreA, 4'b0111, Dash));
        vq.push_back(mk(17,  0, 2'b00, ScoreA, 4'b1110, 7'b0011001));
        vq.push_back(mk(20,  0, 2'b00, ScoreA, 4'b1110, 7'b0011001));
        vq.push_back(mk(21,  0, 2'b00, ScoreA, 4'b1101, 7'b0110000));
        vq.push_back(mk(25,  0, 2'b00, ScoreA, 4'b1011, 7'b0100100));
        vq.push_back(mk(32,  0, 2'b00, ScoreA, 4'b0111, 7'b1111001));
        vq.push_back(mk(33,  0, 2'b00, ScoreA, 4'b1110, 7'b0011001));
        vq.push_back(mk(41,  0, 2'b01, ScoreA, 4'b1011, 7'b0100100));
        vq.push_back(mk(42,  0, 2'b01, ScoreA, 4'b1011, 7'b0100100));
        vq.push_back(mk(45,  0, 2'b01, ScoreA, 4'b0111, 7'b1111001));
        vq.push_back(mk(48,  0, 2'b01, ScoreA, 4'b0111, 7'b1111001));
        vq.push_back(mk(49,  0, 2'b01, ScoreA, 4'b1110, 7'b0000000));
        vq.push_back(mk(53,  0, 2'b00, ScoreA, 4'b1101, 7'b0000000));
        vq.push_back(mk(64,  0, 2'b00, ScoreA, 4'b0111, 7'b0000000));
        vq.push_back(mk(65,  0, 2'b00, ScoreA, 4'b1110, 7'b0011001));
        vq.push_back(mk(69,  0, 2'b00, ScoreA, 4'b1101, 7'b0110000));
        vq.push_back(mk(70,  0, 2'b00, ScoreB, 4'b1101, 7'b0110000));
        vq.push_back(mk(71,  0, 2'b00, ScoreB, 4'b1101, 7'b1111000));
        vq.push_back(mk(73,  0, 2'b00, ScoreB, 4'b1011, 7'b0000010));
        vq.push_back(mk(77,  0, 2'b00, ScoreB, 4'b0111, 7'b0010010));
        vq.push_back(mk(81,  0, 2'b00, ScoreB, 4'b1110, 7'b0000000));
        // One-cycle reset while digit 2 is up, then restart on idle.
        vq.push_back(mk(90,  1, 2'b00, ScoreB, 4'b1011, 7'b0000010));
        vq.push_back(mk(91,  0, 2'b00, ScoreB, 4'b1111, 7'b1111111));
        vq.push_back(mk(92,  0, 2'b00, ScoreB, 4'b1110, Dash));
        vq.push_back(mk(95,  0, 2'b00, ScoreB, 4'b1110, Dash));
        vq.push_back(mk(96,  0, 2'b00, ScoreB, 4'b1101, Dash));
        vq.push_back(mk(107, 0, 2'b00, ScoreB, 4'b0111, Dash));
        vq.push_back(mk(108, 0, 2'b11, ScoreB, 4'b1110, 7'b0000000));
        // Random FFFF: two visible frames, two blanked (with blink), then back to score.
        vq.push_back(mk(123, 0, 2'b11, ScoreB, 4'b0111, 7'b0010010));
        vq.push_back(mk(124, 0, 2'b11, ScoreB, 4'b1110, 7'b0001110));
        vq.push_back(mk(155, 0, 2'b11, ScoreB, 4'b0111, 7'b0001110));
        vq.push_back(mk(156, 0, 2'b11, ScoreB, bl(4'b1110), 7'b0001110));
        vq.push_back(mk(171, 0, 2'b11, ScoreB, bl(4'b0111), 7'b0001110));
        vq.push_back(mk(172, 0, 2'b11, ScoreB, bl(4'b1110), 7'b0001110));
        vq.push_back(mk(188, 0, 2'b00, ScoreB, 4'b1110, 7'b0001110));
        vq.push_back(mk(203, 0, 2'b00, ScoreB, 4'b0111, 7'b0001110));
        vq.push_back(mk(204, 0, 2'b00, ScoreB, 4'b1110, 7'b0000000));
        vq.push_back(mk(220, 0, 2'b00, ScoreB, 4'b1110, 7'b0000000));

        disp.sel_bits   = 2'b00;
        disp.score_val  = ScoreA;
        disp.switch_val = SwVal;
        disp.random_val = RndVal;
        reset           = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset an",  {12'h000, disp.an},  16'h000F);
        chk("reset seg", {9'h000, disp.seg},  16'h007F);
        chk("reset dp",  {15'h0000, disp.dp}, 16'h0001);
        reset  = 1'b0;
        edge_n = 0;

        foreach (vq[i]) begin
            while (edge_n < vq[i].cyc) step();
            chk($sformatf("e%0d an", vq[i].cyc),  {12'h000, disp.an},  {12'h000, vq[i].an});
            chk($sformatf("e%0d seg", vq[i].cyc), {9'h000, disp.seg},  {9'h000, vq[i].seg});
            chk($sformatf("e%0d dp", vq[i].cyc),  {15'h0000, disp.dp}, 16'h0001);
            reset          = vq[i].rst;
            disp.sel_bits  = vq[i].sel;
            disp.score_val = vq[i].score;
        end

        // Any 16 consecutive cycles must hold each digit exactly 4 cycles.
        cnt0 = 0;
        cnt3 = 0;
        repeat (16) begin
            step();
            if (disp.an == 4'b1110) cnt0++;
            if (disp.an == 4'b0111) cnt3++;
        end
        chk("digit0 dwell", 16'(cnt0), 16'd4);
        chk("digit3 dwell", 16'(cnt3), 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
